mux2a1_arb_sched: RTL and testbench

Two-channel buffered scheduler for the 2-bit, 2:1 valid/data lane. Each producer channel writes into its own small FIFO. Each cycle the block picks one non-empty channel, pops one entry, and drives a registered `selector`/`validout`/`dataout` triple. That triple matches what the downstream 2:1 two-bit mux stage expects. The block sits between the two producer channels and the shared lane consumer. It replaces ad-hoc, unsequenced toggling of the mux selector.

---
 rtl/mux2a1_arb_sched_if.sv | 30 +++
 rtl/mux2a1_arb_sched.sv | 155 +++++++++++++++
 tb/tb_mux2a1_arb_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mux2a1_arb_sched_if.sv
// Lane bundle for the two-channel 2:1 scheduler.
// The producer/consumer side uses master; the scheduler uses slave.
interface mux2a1_arb_sched_if #(
    parameter int DATA_W = 2
);
    logic              valid0;
    logic [DATA_W-1:0] data_in0;
    logic              valid1;
    logic [DATA_W-1:0] data_in1;
    logic              pause;
    logic              full0;
    logic              full1;
    logic              err0;
    logic              err1;
    logic              selector;
    logic              validout;
    logic [DATA_W-1:0] dataout;

    modport master (
        output valid0, data_in0, valid1, data_in1, pause,
        input  full0, full1, err0, err1,
        input  selector, validout, dataout
    );

    modport slave (
        input  valid0, data_in0, valid1, data_in1, pause,
        output full0, full1, err0, err1,
        output selector, validout, dataout
    );
endinterface

// File: rtl/mux2a1_arb_sched.sv
// Two-channel FIFO scheduler driving a registered 2:1 selector/valid/data lane.
// Define ARB_FIXED_PRIO_EN for strict channel-0 priority on ties.
module mux2a1_arb_sched #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 2
) (
    input logic              clk,
    input logic              reset,
    mux2a1_arb_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [DATA_W-1:0] mem_d [2][DEPTH];
    logic [CW-1:0]     cnt_q [2];
    logic [CW-1:0]     cnt_d [2];
    logic [AW-1:0]     wr_q  [2];
    logic [AW-1:0]     wr_d  [2];
    logic [AW-1:0]     rd_q  [2];
    logic [AW-1:0]     rd_d  [2];
    logic [DATA_W-1:0] din   [2];

    logic [1:0] err_q, err_d;
    logic [1:0] vin, full, elig, push, pop;

    logic              last_grant_q, last_grant_d;
    logic              sel_q, sel_d;
    logic              vout_q, vout_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    assign vin    = {bus.valid1, bus.valid0};
    assign din[0] = bus.data_in0;
    assign din[1] = bus.data_in1;

    // Full and eligibility look only at the pre-edge count.
    always_comb begin
        full = '0;
        elig = '0;
        push = '0;
        for (int n = 0; n < 2; n++) begin
            full[n] = (cnt_q[n] == CW'(DEPTH));
            elig[n] = (cnt_q[n] != '0);
            push[n] = vin[n] & ~full[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (bus.pause || elig == 2'b00) begin
            state_d = IDLE;
        end else if (elig == 2'b01) begin
            state_d = G0;
        end else if (elig == 2'b10) begin
            state_d = G1;
        end else begin
`ifdef ARB_FIXED_PRIO_EN
            state_d = G0;
`else
            state_d = last_grant_q ? G0 : G1;
`endif
        end
    end

    // The grant taken at this edge is the state being entered.
    always_comb begin
        pop          = '0;
        vout_d       = 1'b0;
        dout_d       = dout_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        unique case (state_d)
            G0: begin
                pop[0]       = 1'b1;
                vout_d       = 1'b1;
                dout_d       = mem_q[0][rd_q[0]];
                sel_d        = 1'b0;
                last_grant_d = 1'b0;
            end
            G1: begin
                pop[1]       = 1'b1;
                vout_d       = 1'b1;
                dout_d       = mem_q[1][rd_q[1]];
                sel_d        = 1'b1;
                last_grant_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            mem_d[n] = mem_q[n];
            wr_d[n]  = wr_q[n];
            rd_d[n]  = rd_q[n];
            if (push[n]) begin
                mem_d[n][wr_q[n]] = din[n];
                wr_d[n] = wr_q[n] + AW'(1);
            end
            if (pop[n]) begin
                rd_d[n] = rd_q[n] + AW'(1);
            end
            cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
        end
        err_d = err_q | (vin & full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            cnt_q        <= '{default: '0};
            wr_q         <= '{default: '0};
            rd_q         <= '{default: '0};
            err_q        <= '0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            vout_q       <= 1'b0;
            dout_q       <= '0;
        end else begin
            mem_q        <= mem_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            vout_q       <= vout_d;
            dout_q       <= dout_d;
        end
    end

    assign bus.full0    = full[0];
    assign bus.full1    = full[1];
    assign bus.err0     = err_q[0];
    assign bus.err1     = err_q[1];
    assign bus.selector = sel_q;
    assign bus.validout = vout_q;
    assign bus.dataout  = dout_q;
endmodule

// File: tb/tb_mux2a1_arb_sched.sv
// Scoreboard bench for mux2a1_arb_sched: expected {selector,data}
// are queued at stimulus time and popped whenever validout is seen.
module tb_mux2a1_arb_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;

    mux2a1_arb_sched_if #(.DATA_W(2)) bus ();

    mux2a1_arb_sched #(.DEPTH(4), .DATA_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic v0, input logic [1:0] d0,
                         input logic v1, input logic [1:0] d1);
        bus.valid0   = v0;
        bus.data_in0 = d0;
        bus.valid1   = v1;
        bus.data_in1 = d1;
        tick();
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;
    endtask

    task automatic exp_push(input logic s, input logic [1:0] d);
        exp_q.push_back({s, d});
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_vout"}, bus.validout, 0);
        chk({tag, "_dout"}, bus.dataout, 0);
        chk({tag, "_sel"}, bus.selector, 0);
        chk({tag, "_full0"}, bus.full0, 0);
        chk({tag, "_full1"}, bus.full1, 0);
        chk({tag, "_err1"}, bus.err1, 0);
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        logic [2:0] e;
        if (!reset && bus.validout) begin
            chk("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_sel", bus.selector, e[2]);
                chk("sb_data", bus.dataout, e[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid0   = 1'b0;
        bus.valid1   = 1'b0;
        bus.data_in0 = '0;
        bus.data_in1 = '0;
        bus.pause    = 1'b0;
        reset        = 1'b1;
        #2;
        chk("rst_vout", bus.validout, 0);
        chk("rst_err0", bus.err0, 0);
        chk("rst_err1", bus.err1, 0);
        tick();
        tick();
        reset = 1'b0;

        // single channel latency and hold
        exp_push(1'b0, 2'b10);
        push2(1'b1, 2'b10, 1'b0, 2'b00);
        chk("s1_lat0", bus.validout, 0);
        tick();
        chk("s1_vout", bus.validout, 1);
        chk("s1_dout", bus.dataout, 2'b10);
        tick();
        chk("s1_idle", bus.validout, 0);
        chk("s1_hold", bus.dataout, 2'b10);

        // round-robin from fresh reset
        async_reset("r1");
        bus.pause = 1'b1;
        push2(1'b1, 2'b01, 1'b1, 2'b11);
        push2(1'b1, 2'b10, 1'b1, 2'b00);
        chk("rr_paused", bus.validout, 0);
        chk("rr_full0", bus.full0, 0);
`ifdef ARB_FIXED_PRIO_EN
        exp_push(1'b0, 2'b01);
        exp_push(1'b0, 2'b10);
        exp_push(1'b1, 2'b11);
        exp_push(1'b1, 2'b00);
`else
        exp_push(1'b0, 2'b01);
        exp_push(1'b1, 2'b11);
        exp_push(1'b0, 2'b10);
        exp_push(1'b1, 2'b00);
`endif
        bus.pause = 1'b0;
        repeat (4) tick();
        tick();
        chk("rr_end", bus.validout, 0);
        chk("rr_drain", exp_q.size(), 0);

        // fill and overflow ch1 while paused
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("ov_full3", bus.full1, 0);
            push2(1'b0, 2'b00, 1'b1, 2'(i));
            exp_push(1'b1, 2'(i));
        end
        chk("ov_full", bus.full1, 1);
        chk("ov_err_pre", bus.err1, 0);
        push2(1'b0, 2'b00, 1'b1, 2'b11);
        chk("ov_err", bus.err1, 1);
        chk("ov_full5", bus.full1, 1);
        chk("ov_err0", bus.err0, 0);
        bus.pause = 1'b0;
        repeat (4) tick();
        tick();
        chk("ov_end", bus.validout, 0);
        chk("ov_sticky", bus.err1, 1);
        chk("ov_nfull", bus.full1, 0);
        chk("ov_drain", exp_q.size(), 0);

        // reset while both FIFOs hold data
        bus.pause = 1'b1;
        push2(1'b1, 2'b11, 1'b1, 2'b01);
        push2(1'b1, 2'b10, 1'b1, 2'b10);
        exp_push(1'b0, 2'b11);
        bus.pause = 1'b0;
        tick();
        bus.pause = 1'b1;
        tick();
        chk("mr_paused", bus.validout, 0);
        chk("mr_held", bus.dataout, 2'b11);
        async_reset("r2");
        bus.pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_empty", bus.validout, 0);
        end
        chk("mr_drain", exp_q.size(), 0);

        // pause mid-stream with both channels backlogged
        bus.pause = 1'b1;
        push2(1'b1, 2'b01, 1'b1, 2'b10);
        push2(1'b1, 2'b10, 1'b1, 2'b11);
        push2(1'b1, 2'b11, 1'b1, 2'b01);
`ifdef ARB_FIXED_PRIO_EN
        exp_push(1'b0, 2'b01);
        exp_push(1'b0, 2'b10);
        exp_push(1'b0, 2'b11);
        exp_push(1'b1, 2'b10);
        exp_push(1'b1, 2'b11);
        exp_push(1'b1, 2'b01);
`else
        exp_push(1'b0, 2'b01);
        exp_push(1'b1, 2'b10);
        exp_push(1'b0, 2'b10);
        exp_push(1'b1, 2'b11);
        exp_push(1'b0, 2'b11);
        exp_push(1'b1, 2'b01);
`endif
        bus.pause = 1'b0;
        tick();
        tick();
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pm_pause", bus.validout, 0);
        end
        bus.pause = 1'b0;
        repeat (4) tick();
        tick();
        chk("pm_end", bus.validout, 0);
        chk("pm_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
